// File: rtl/muladd_ctrl.sv
// muladd_ctrl: batch sequencer for the HLS muladd dot-product core.
// Buffers N operand pairs from a valid/ready stream, drives ap_start and
// serves the core's single-read-port a/b memories from those buffers, then
// presents ap_return plus the run-cycle count on a valid/ready output.
module muladd_ctrl #(
    parameter int N  = 16,
    parameter int DW = 16,
    parameter int RW = 32,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    // operand stream
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    // result stream
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_result,
    output logic [15:0]   out_cycles,
    output logic          busy,
    // core control (ap_ctrl_hs)
    output logic          core_start,
    input  logic          core_ready,
    input  logic          core_done,
    input  logic          core_idle,
    input  logic [RW-1:0] core_return,
    // core memory ports
    input  logic [AW-1:0] a_address0,
    input  logic          a_ce0,
    output logic [DW-1:0] a_q0,
    input  logic [AW-1:0] b_address0,
    input  logic          b_ce0,
    output logic [DW-1:0] b_q0
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_PTR = AW'(N - 1);
    // one extra bit so the range check stays meaningful when N == 2^AW
    localparam logic [AW:0]   N_LIM    = (AW + 1)'(N);

    state_t        state_q;
    logic [AW-1:0] wr_ptr_q;
    logic          core_start_q;
    logic          out_valid_q;
    logic [RW-1:0] out_result_q;
    logic [15:0]   out_cycles_q;
    logic [15:0]   cyc_q;
    logic [15:0]   cyc_d;
    logic [DW-1:0] a_q0_q;
    logic [DW-1:0] b_q0_q;
    logic [DW-1:0] a_rd_d;
    logic [DW-1:0] b_rd_d;

    // operand buffers: contents survive reset, only wr_ptr is cleared
    logic [DW-1:0] buf_a [N];
    logic [DW-1:0] buf_b [N];

    logic accept;
    logic serving;

    // ap_idle is only of interest to debug logic outside this block
    logic unused_idle;
    assign unused_idle = core_idle;

    assign in_ready   = (state_q == S_LOAD) & ~rst;
    assign accept     = in_valid & in_ready;
    assign serving    = (state_q == S_START) | (state_q == S_RUN);
    assign busy       = serving;
    assign core_start = core_start_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_cycles = out_cycles_q;
    assign a_q0       = a_q0_q;
    assign b_q0       = b_q0_q;

    // run-cycle counter increment, pinned at all-ones
    assign cyc_d = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;

    // out-of-range addresses read as zero
    assign a_rd_d = ({1'b0, a_address0} < N_LIM) ? buf_a[a_address0] : '0;
    assign b_rd_d = ({1'b0, b_address0} < N_LIM) ? buf_b[b_address0] : '0;

    // capture accepted operand beats into the buffers
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_a[wr_ptr_q] <= in_a;
            buf_b[wr_ptr_q] <= in_b;
        end
    end

    // batch sequencer: LOAD -> START -> RUN -> OUT, ready+done in START skips RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_LOAD;
            wr_ptr_q     <= '0;
            core_start_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_cycles_q <= '0;
            cyc_q        <= '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (accept) begin
                        if (wr_ptr_q == LAST_PTR) begin
                            wr_ptr_q     <= '0;
                            state_q      <= S_START;
                            core_start_q <= 1'b1;
                            cyc_q        <= '0;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                        end
                    end
                end
                S_START: begin
                    cyc_q <= cyc_d;
                    // ap_start is held until the core acknowledges with ap_ready
                    if (core_ready) begin
                        core_start_q <= 1'b0;
                        if (core_done) begin
                            out_result_q <= core_return;
                            out_cycles_q <= cyc_d;
                            out_valid_q  <= 1'b1;
                            state_q      <= S_OUT;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    cyc_q <= cyc_d;
                    if (core_done) begin
                        out_result_q <= core_return;
                        out_cycles_q <= cyc_d;
                        out_valid_q  <= 1'b1;
                        state_q      <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_LOAD;
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    // one-cycle-latency read ports, data holds when not enabled or not running
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q0_q <= '0;
            b_q0_q <= '0;
        end else begin
            if (serving && a_ce0) a_q0_q <= a_rd_d;
            if (serving && b_ce0) b_q0_q <= b_rd_d;
        end
    end

endmodule

// File: tb/tb_muladd_ctrl.sv
// tb_muladd_ctrl: drives muladd_ctrl with directed and random batches against
// a behavioural muladd core model that reads operands through the memory
// ports; expected dot products come from a plain arithmetic reference.
module tb_muladd_ctrl;

    localparam int NN = 16;
    localparam logic [31:0] FAST_RET = 32'h1234_5678;
    localparam logic [31:0] MAN_RET  = 32'hCAFE_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [15:0] out_cycles;
    logic        busy;
    logic        core_start;
    logic        core_ready;
    logic        core_done;
    logic        core_idle;
    logic [31:0] core_return;
    logic [3:0]  a_address0;
    logic        a_ce0;
    logic [15:0] a_q0;
    logic [3:0]  b_address0;
    logic        b_ce0;
    logic [15:0] b_q0;

    always #5 clk = ~clk;

    muladd_ctrl #(.N(16), .DW(16), .RW(32), .AW(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_cycles(out_cycles), .busy(busy),
        .core_start(core_start), .core_ready(core_ready), .core_done(core_done),
        .core_idle(core_idle), .core_return(core_return),
        .a_address0(a_address0), .a_ce0(a_ce0), .a_q0(a_q0),
        .b_address0(b_address0), .b_ce0(b_ce0), .b_q0(b_q0)
    );

    // ---------------- core model ----------------
    int          mode;      // 0 normal, 1 ready+done with start, 2 manual
    int          rdy_dly;
    logic        c_ready, c_done, c_ce;
    logic [31:0] c_ret;
    logic [3:0]  c_addr;
    logic        m_ready, m_done, m_ce;
    logic [31:0] m_ret;
    logic [3:0]  m_addr;
    int          cst, k, wcnt;
    logic [31:0] acc;
    logic        man;

    assign man         = (mode == 2);
    assign core_ready  = man ? m_ready : c_ready;
    assign core_done   = man ? m_done  : c_done;
    assign core_return = man ? m_ret   : c_ret;
    assign a_address0  = man ? m_addr  : c_addr;
    assign b_address0  = man ? m_addr  : c_addr;
    assign a_ce0       = man ? m_ce    : c_ce;
    assign b_ce0       = man ? m_ce    : c_ce;
    assign core_idle   = (cst == 0);

    // behavioural muladd: read a[k],b[k] for k=0..N-1, accumulate, then ap_done
    always @(posedge clk) begin
        #1;
        c_ready = 1'b0;
        c_done  = 1'b0;
        c_ce    = 1'b0;
        if (rst) begin
            cst  = 0;
            wcnt = 0;
        end else if (cst == 0) begin
            if (core_start && mode == 1) begin
                c_ready = 1'b1;
                c_done  = 1'b1;
                c_ret   = FAST_RET;
            end else if (core_start && mode == 0) begin
                if (wcnt < rdy_dly) wcnt++;
                else begin
                    wcnt    = 0;
                    c_ready = 1'b1;
                    c_addr  = 4'd0;
                    c_ce    = 1'b1;
                    k       = 1;
                    acc     = 32'd0;
                    cst     = 1;
                end
            end
        end else begin
            acc = acc + 32'(a_q0) * 32'(b_q0);
            if (k < NN) begin
                c_addr = 4'(k);
                c_ce   = 1'b1;
                k++;
            end else begin
                c_done = 1'b1;
                c_ret  = acc;
                cst    = 0;
            end
        end
    end

    // measure cycles from first ap_start to ap_done inclusive, seen from the core side
    int scnt, meas;
    bit act;
    always @(negedge clk) begin
        #2;
        if (rst) act = 1'b0;
        else begin
            if (!act && core_start) begin
                act  = 1'b1;
                scnt = 0;
            end
            if (act) begin
                scnt++;
                if (core_done) begin
                    meas = scnt;
                    act  = 1'b0;
                end
            end
        end
    end

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_pass = 0;
    logic [15:0] ba [NN];
    logic [15:0] bb [NN];

    task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_chk++;
        if (act_v === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act_v, exp_v);
    endtask

    function automatic logic [31:0] ref_dot();
        logic [31:0] s;
        s = 32'd0;
        for (int i = 0; i < NN; i++) s = s + 32'(ba[i]) * 32'(bb[i]);
        return s;
    endfunction

    function automatic logic [15:0] fa(input int i);
        return 16'hA000 + 16'(i);
    endfunction

    function automatic logic [15:0] fb(input int i);
        return 16'h0B00 + 16'(3 * i);
    endfunction

    // stream ba/bb in; called at a negedge with the DUT in LOAD, returns at the
    // negedge of the first START cycle
    task automatic send_batch(input bit gaps);
        int g;
        for (int i = 0; i < NN; i++) begin
            g = gaps ? int'($urandom_range(0, 2)) : 0;
            for (int j = 0; j < g; j++) begin
                in_valid = 1'b0;
                chk("gap_no_start", {31'd0, core_start}, 32'd0);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_a     = ba[i];
            in_b     = bb[i];
            chk("beat_in_ready", {31'd0, in_ready}, 32'd1);
            chk("beat_no_start", {31'd0, core_start}, 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("start_after_last", {31'd0, core_start}, 32'd1);
        chk("start_in_ready", {31'd0, in_ready}, 32'd0);
        chk("start_busy", {31'd0, busy}, 32'd1);
    endtask

    // wait for the result, hold back-pressure for 'hold' cycles, then release
    task automatic get_result(input string nm, input logic [31:0] er, input int hold);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
        if (!out_valid) return;
        chk({nm, "_result"}, out_result, er);
        chk({nm, "_cycles"}, 32'(out_cycles), 32'(meas));
        chk({nm, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({nm, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            chk({nm, "_hold_result"}, out_result, er);
            chk({nm, "_hold_cycles"}, 32'(out_cycles), 32'(meas));
            chk({nm, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({nm, "_post_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({nm, "_post_valid"}, {31'd0, out_valid}, 32'd0);
        chk({nm, "_post_busy"}, {31'd0, busy}, 32'd0);
    endtask

    typedef struct {
        logic [3:0]  addr;
        logic        ce;
        logic [15:0] ea;
        logic [15:0] eb;
    } mv_t;

    mv_t tv [7];

    initial begin
        // memory-port vectors: expected q0 one cycle after the request
        tv[0] = '{4'd5,  1'b1, fa(5),  fb(5)};
        tv[1] = '{4'd9,  1'b0, fa(5),  fb(5)};
        tv[2] = '{4'd2,  1'b0, fa(5),  fb(5)};
        tv[3] = '{4'd12, 1'b0, fa(5),  fb(5)};
        tv[4] = '{4'd15, 1'b1, fa(15), fb(15)};
        tv[5] = '{4'd0,  1'b1, fa(0),  fb(0)};
        tv[6] = '{4'd7,  1'b0, fa(0),  fb(0)};

        mode = 0; rdy_dly = 0;
        m_ready = 0; m_done = 0; m_ce = 0; m_ret = 0; m_addr = 0;
        in_valid = 0; in_a = 0; in_b = 0; out_ready = 0;
        meas = 0; scnt = 0; act = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_core_start", {31'd0, core_start}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_cycles", 32'(out_cycles), 32'd0);
        chk("rst_a_q0", 32'(a_q0), 32'd0);
        chk("rst_b_q0", 32'(b_q0), 32'd0);
        rst = 1'b0;
        #1 chk("rst_release_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // basic dot product
        for (int i = 0; i < NN; i++) begin ba[i] = 16'(i + 1); bb[i] = 16'd2; end
        send_batch(1'b0);
        get_result("basic", 32'd272, 0);
        chk("basic_cycles_abs", 32'(out_cycles), 32'd17);

        // input gaps, same data
        send_batch(1'b1);
        get_result("gaps", 32'd272, 0);

        // output back-pressure for 10 cycles, then a second batch
        for (int i = 0; i < NN; i++) begin ba[i] = 16'($urandom); bb[i] = 16'($urandom); end
        send_batch(1'b0);
        get_result("bp", ref_dot(), 10);
        for (int i = 0; i < NN; i++) begin ba[i] = 16'($urandom); bb[i] = 16'($urandom); end
        send_batch(1'b1);
        get_result("bp_second", ref_dot(), 0);

        // ap_done while in LOAD must be ignored
        mode = 2;
        m_done = 1'b1;
        m_ret = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("load_done_valid", {31'd0, out_valid}, 32'd0);
        chk("load_done_in_ready", {31'd0, in_ready}, 32'd1);
        m_done = 1'b0;

        // memory port reads with the core driven by hand
        for (int i = 0; i < NN; i++) begin ba[i] = fa(i); bb[i] = fb(i); end
        send_batch(1'b0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("start_held", {31'd0, core_start}, 32'd1);
        end
        for (int r = 0; r < 7; r++) begin
            m_addr = tv[r].addr;
            m_ce   = tv[r].ce;
            @(negedge clk);
            chk("mem_a_q0", 32'(a_q0), 32'(tv[r].ea));
            chk("mem_b_q0", 32'(b_q0), 32'(tv[r].eb));
        end
        m_ce = 1'b0;
        m_ready = 1'b1;
        m_done = 1'b1;
        m_ret = MAN_RET;
        @(posedge clk);
        #1 begin m_ready = 1'b0; m_done = 1'b0; end
        get_result("manual", MAN_RET, 0);

        // ready and done together with start: straight to OUT, one cycle
        mode = 1;
        for (int i = 0; i < NN; i++) begin ba[i] = 16'($urandom); bb[i] = 16'($urandom); end
        send_batch(1'b0);
        @(negedge clk);
        chk("fast_valid", {31'd0, out_valid}, 32'd1);
        chk("fast_no_run", {31'd0, busy}, 32'd0);
        chk("fast_cycles_abs", 32'(out_cycles), 32'd1);
        get_result("fast", FAST_RET, 0);

        // reset during RUN
        mode = 0;
        rdy_dly = 0;
        for (int i = 0; i < NN; i++) begin ba[i] = 16'($urandom); bb[i] = 16'($urandom); end
        send_batch(1'b0);
        repeat (4) @(negedge clk);
        chk("run_busy", {31'd0, busy}, 32'd1);
        chk("run_start_low", {31'd0, core_start}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_core_start", {31'd0, core_start}, 32'd0);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_out_result", out_result, 32'd0);
        chk("mid_rst_out_cycles", 32'(out_cycles), 32'd0);
        chk("mid_rst_a_q0", 32'(a_q0), 32'd0);
        chk("mid_rst_b_q0", 32'(b_q0), 32'd0);
        rst = 1'b0;
        #1 chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        for (int i = 0; i < NN; i++) begin ba[i] = 16'd3; bb[i] = 16'd3; end
        send_batch(1'b0);
        get_result("after_rst", 32'd144, 0);

        // random batches
        for (int t = 0; t < 6; t++) begin
            rdy_dly = int'($urandom_range(0, 3));
            for (int i = 0; i < NN; i++) begin ba[i] = 16'($urandom); bb[i] = 16'($urandom); end
            send_batch(1'b1);
            get_result("rand", ref_dot(), int'($urandom_range(0, 4)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
